// File: rtl/cache_adaptor_pkg.sv
// Shared types and sizing for the cache-line <-> 64-bit burst adaptor.
// The burst geometry is fixed here; BEATS is derived from the two widths.
package cache_adaptor_pkg;

  localparam int ADDR_W   = 32;
  localparam int LINE_W   = 256;
  localparam int BURST_W  = 64;
  localparam int BEATS    = LINE_W / BURST_W;
  localparam int OFFSET_W = 5;
  localparam int CNT_W    = $clog2(BEATS);

  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W - OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

  typedef logic [LINE_W-1:0]  line_t;
  typedef logic [BURST_W-1:0] beat_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_BURST,
    RD_DONE,
    WR_BURST,
    WR_DONE
  } adaptor_state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Turns one 256-bit cache-line request into a 4-beat 64-bit memory burst.
// Reads gather beats into a line; writes slice a latched line into beats.
module cacheline_adaptor
  import cache_adaptor_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o,
  input  logic [ADDR_W-1:0] address_i,
  input  logic              read_i,
  input  logic              write_i,
  output logic              resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0] address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i
);

  adaptor_state_t   state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] next_cnt;
  line_t            line_buf;
  line_t            gathered;

  // The final read beat is merged here so line_o is complete in RD_DONE.
  always_comb begin
    next_cnt = cnt + 1'b1;
    gathered = line_buf;
    gathered[BURST_W*cnt +: BURST_W] = burst_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      line_buf  <= '0;
      line_o    <= '0;
      burst_o   <= '0;
      address_o <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
    end else begin
      resp_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (write_i) begin
            address_o <= address_i & LINE_MASK;
            line_buf  <= line_i;
            burst_o   <= line_i[BURST_W-1:0];
            cnt       <= '0;
            write_o   <= 1'b1;
            state     <= WR_BURST;
          end else if (read_i) begin
            address_o <= address_i & LINE_MASK;
            cnt       <= '0;
            read_o    <= 1'b1;
            state     <= RD_BURST;
          end
        end
        RD_BURST: begin
          if (resp_i) begin
            line_buf <= gathered;
            if (cnt == LAST_BEAT) begin
              line_o <= gathered;
              read_o <= 1'b0;
              resp_o <= 1'b1;
              state  <= RD_DONE;
            end else begin
              cnt <= next_cnt;
            end
          end
        end
        RD_DONE: state <= IDLE;
        WR_BURST: begin
          // burst_o only advances on an accepted beat, so memory may stall freely.
          if (resp_i) begin
            if (cnt == LAST_BEAT) begin
              write_o <= 1'b0;
              resp_o  <= 1'b1;
              state   <= WR_DONE;
            end else begin
              cnt     <= next_cnt;
              burst_o <= line_buf[BURST_W*next_cnt +: BURST_W];
            end
          end
        end
        WR_DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: the bench plays both cache and memory,
// driving and sampling on the falling edge.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [255:0] line_i, line_o;
  logic [31:0]  address_i, address_o;
  logic         read_i, write_i, resp_o;
  logic [63:0]  burst_i, burst_o;
  logic         read_o, write_o, resp_i;

  int n_compared   = 0;
  int n_mismatched = 0;

  localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] WA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] WB = 64'hBBBB_BBBB_BBBB_BBBB;
  localparam logic [63:0] WC = 64'hCCCC_CCCC_CCCC_CCCC;
  localparam logic [63:0] WD = 64'hDDDD_DDDD_DDDD_DDDD;

  logic [255:0] line_1234;

  cacheline_adaptor dut (
    .clk(clk), .reset_n(reset_n),
    .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset_n = 1'b0; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    burst_i = '0; resp_i = 1'b0;
    repeat (2) @(negedge clk);
    n_compared++;
    if ({resp_o, read_o, write_o} !== 3'b000) begin
      n_mismatched++; $display("FAIL reset_ctrl: got %b want 000", {resp_o, read_o, write_o});
    end
    n_compared++;
    if (line_o !== 256'd0 || burst_o !== 64'd0 || address_o !== 32'd0) begin
      n_mismatched++; $display("FAIL reset_data: line_o %h burst_o %h address_o %h want all 0", line_o, burst_o, address_o);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_back_to_back();
    address_i = 32'h0000_1234; read_i = 1'b1;
    @(negedge clk);
    n_compared++;
    if (read_o !== 1'b1 || address_o !== 32'h0000_1220) begin
      n_mismatched++; $display("FAIL rd_launch: read_o %b address_o %h want 1 00001220", read_o, address_o);
    end
    resp_i = 1'b1;
    burst_i = B1; @(negedge clk);
    burst_i = B2; @(negedge clk);
    burst_i = B3; @(negedge clk);
    n_compared++;
    if (resp_o !== 1'b0) begin
      n_mismatched++; $display("FAIL rd_early_resp: resp_o %b want 0", resp_o);
    end
    burst_i = B4; @(negedge clk);
    resp_i = 1'b0; burst_i = '0;
    n_compared++;
    if (resp_o !== 1'b1 || read_o !== 1'b0) begin
      n_mismatched++; $display("FAIL rd_resp: resp_o %b read_o %b want 1 0", resp_o, read_o);
    end
    n_compared++;
    if (line_o !== line_1234) begin
      n_mismatched++; $display("FAIL rd_line: got %h want %h", line_o, line_1234);
    end
    read_i = 1'b0;
    @(negedge clk);
    n_compared++;
    if (resp_o !== 1'b0 || line_o !== line_1234) begin
      n_mismatched++; $display("FAIL rd_resp_width: resp_o %b line_o %h want 0 %h", resp_o, line_o, line_1234);
    end
    @(negedge clk);
  endtask

  task automatic test_read_gaps();
    logic held;
    address_i = 32'h0000_1234; read_i = 1'b1;
    @(negedge clk);
    held = read_o;
    resp_i = 1'b1;
    burst_i = B1; @(negedge clk);
    held &= read_o;
    burst_i = B2; @(negedge clk);
    held &= read_o;
    resp_i = 1'b0; burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
    repeat (2) begin
      @(negedge clk);
      held &= read_o;
    end
    n_compared++;
    if (resp_o !== 1'b0) begin
      n_mismatched++; $display("FAIL gap_no_early_resp: resp_o %b want 0", resp_o);
    end
    resp_i = 1'b1;
    burst_i = B3; @(negedge clk);
    held &= read_o;
    burst_i = B4; @(negedge clk);
    resp_i = 1'b0; burst_i = '0;
    n_compared++;
    if (held !== 1'b1) begin
      n_mismatched++; $display("FAIL gap_read_held: read_o held %b want 1", held);
    end
    n_compared++;
    if (resp_o !== 1'b1 || line_o !== line_1234) begin
      n_mismatched++; $display("FAIL gap_line: resp_o %b line_o %h want 1 %h", resp_o, line_o, line_1234);
    end
    read_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    line_i = {WD, WC, WB, WA}; address_i = 32'h8000_004C; write_i = 1'b1;
    @(negedge clk);
    n_compared++;
    if (write_o !== 1'b1 || read_o !== 1'b0 || address_o !== 32'h8000_0040) begin
      n_mismatched++; $display("FAIL wr_launch: write_o %b read_o %b address_o %h want 1 0 80000040", write_o, read_o, address_o);
    end
    n_compared++;
    if (burst_o !== WA) begin
      n_mismatched++; $display("FAIL wr_beat0: got %h want %h", burst_o, WA);
    end
    resp_i = 1'b1; @(negedge clk);
    resp_i = 1'b0; @(negedge clk);
    n_compared++;
    if (burst_o !== WB || write_o !== 1'b1) begin
      n_mismatched++; $display("FAIL wr_beat1_hold: burst_o %h write_o %b want %h 1", burst_o, write_o, WB);
    end
    resp_i = 1'b1; @(negedge clk);
    n_compared++;
    if (burst_o !== WC) begin
      n_mismatched++; $display("FAIL wr_beat2: got %h want %h", burst_o, WC);
    end
    @(negedge clk);
    n_compared++;
    if (burst_o !== WD || resp_o !== 1'b0) begin
      n_mismatched++; $display("FAIL wr_beat3: burst_o %h resp_o %b want %h 0", burst_o, resp_o, WD);
    end
    @(negedge clk);
    resp_i = 1'b0;
    n_compared++;
    if (resp_o !== 1'b1 || write_o !== 1'b0) begin
      n_mismatched++; $display("FAIL wr_resp: resp_o %b write_o %b want 1 0", resp_o, write_o);
    end
    n_compared++;
    if (line_o !== line_1234) begin
      n_mismatched++; $display("FAIL wr_line_o_untouched: got %h want %h", line_o, line_1234);
    end
    write_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    logic [63:0]  rb [4];
    logic [255:0] exp_line;
    rb[0] = 64'h0123_4567_89AB_CDEF; rb[1] = 64'hFEDC_BA98_7654_3210;
    rb[2] = 64'h0F0F_0F0F_0F0F_0F0F; rb[3] = 64'hF0F0_F0F0_F0F0_F0F0;
    exp_line = {rb[3], rb[2], rb[1], rb[0]};
    line_i = {WA, WB, WC, WD}; address_i = 32'h0000_2008;
    read_i = 1'b1; write_i = 1'b1;
    @(negedge clk);
    n_compared++;
    if (write_o !== 1'b1 || read_o !== 1'b0 || burst_o !== WD || address_o !== 32'h0000_2000) begin
      n_mismatched++; $display("FAIL both_write_first: write_o %b read_o %b burst_o %h address_o %h", write_o, read_o, burst_o, address_o);
    end
    resp_i = 1'b1;
    repeat (4) @(negedge clk);
    resp_i = 1'b0;
    n_compared++;
    if (resp_o !== 1'b1 || write_o !== 1'b0) begin
      n_mismatched++; $display("FAIL both_write_resp: resp_o %b write_o %b want 1 0", resp_o, write_o);
    end
    write_i = 1'b0;
    @(negedge clk);
    n_compared++;
    if (resp_o !== 1'b0 || read_o !== 1'b0) begin
      n_mismatched++; $display("FAIL both_gap: resp_o %b read_o %b want 0 0", resp_o, read_o);
    end
    @(negedge clk);
    n_compared++;
    if (read_o !== 1'b1 || address_o !== 32'h0000_2000) begin
      n_mismatched++; $display("FAIL both_read_launch: read_o %b address_o %h want 1 00002000", read_o, address_o);
    end
    resp_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      burst_i = rb[i];
      @(negedge clk);
    end
    resp_i = 1'b0; burst_i = '0;
    n_compared++;
    if (resp_o !== 1'b1 || line_o !== exp_line) begin
      n_mismatched++; $display("FAIL both_read_line: resp_o %b line_o %h want 1 %h", resp_o, line_o, exp_line);
    end
    read_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    logic [255:0] exp_line;
    logic         saw_resp;
    exp_line = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};
    address_i = 32'h0000_0040; read_i = 1'b1;
    @(negedge clk);
    resp_i = 1'b1;
    burst_i = B1; @(negedge clk);
    burst_i = B2; @(negedge clk);
    resp_i = 1'b0;
    #2 reset_n = 1'b0; read_i = 1'b0;
    #1;
    n_compared++;
    if ({resp_o, read_o, write_o} !== 3'b000 || address_o !== 32'd0 || line_o !== 256'd0 || burst_o !== 64'd0) begin
      n_mismatched++; $display("FAIL async_reset: ctrl %b address_o %h line_o %h burst_o %h want all 0", {resp_o, read_o, write_o}, address_o, line_o, burst_o);
    end
    @(negedge clk);
    reset_n = 1'b1;
    saw_resp = 1'b0;
    repeat (3) begin
      @(negedge clk);
      saw_resp |= resp_o | read_o;
    end
    n_compared++;
    if (saw_resp !== 1'b0) begin
      n_mismatched++; $display("FAIL reset_no_resp: resp_o/read_o seen %b want 0", saw_resp);
    end
    address_i = 32'h0000_0064; read_i = 1'b1;
    @(negedge clk);
    resp_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      burst_i = exp_line[64*i +: 64];
      @(negedge clk);
    end
    resp_i = 1'b0; burst_i = '0;
    n_compared++;
    if (resp_o !== 1'b1 || line_o !== exp_line || address_o !== 32'h0000_0060) begin
      n_mismatched++; $display("FAIL reset_fresh_read: resp_o %b address_o %h line_o %h want 1 00000060 %h", resp_o, address_o, line_o, exp_line);
    end
    read_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_idle_resp();
    logic [255:0] prev_line;
    logic         bad;
    prev_line = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                 64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};
    bad = 1'b0;
    resp_i = 1'b1; burst_i = 64'hDEAD_BEEF_CAFE_F00D;
    repeat (3) begin
      @(negedge clk);
      bad |= resp_o | read_o | write_o;
    end
    resp_i = 1'b0;
    @(negedge clk);
    bad |= resp_o | read_o | write_o;
    n_compared++;
    if (bad !== 1'b0) begin
      n_mismatched++; $display("FAIL idle_resp_ctrl: activity %b want 0", bad);
    end
    n_compared++;
    if (line_o !== prev_line) begin
      n_mismatched++; $display("FAIL idle_resp_line: got %h want %h", line_o, prev_line);
    end
  endtask

  initial begin
    line_1234 = {B4, B3, B2, B1};
    test_reset();
    test_read_back_to_back();
    test_read_gaps();
    test_write();
    test_simultaneous();
    test_reset_mid_read();
    test_idle_resp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
